// File: rtl/wb_loader.sv
// -----------------------------------------------------------------------------
// wb_loader
//
// Run-time writer for the weight/bias bank set. After a start pulse it
// accepts a 32-bit word stream and turns every accepted word into one
// registered bank write. The order is bank-major:
//   banks 0 .. L1_BANKS-1                  : L1_WORDS words each ([W1|b1])
//   banks L1_BANKS .. L1_BANKS+L2_BANKS-1  : L2_WORDS words each ([W2|b2])
// A one-cycle done pulse tells the inference controller that the load is
// complete.
//
// Optional feature (macro WB_LOADER_CKSUM_EN):
//   A mod-2^32 running sum of all bank data words is kept. After the last
//   layer-2 word one extra stream word (the expected checksum) is accepted
//   and compared against it; o_cksum_err reports a mismatch and holds until
//   the next start or reset. Without the macro o_cksum_err is tied to 0.
//
// Stream handshake: a word transfers on every rising clk edge where
// i_s_valid && o_s_ready. o_s_ready depends only on the FSM state (never on
// i_s_valid), and i_s_data is sampled only on a transfer.
//
// Ports:
//   i_clk        clock
//   i_resetn     asynchronous active-low reset
//   i_start      one-cycle pulse, begins a load when idle
//   i_s_valid    stream word valid
//   i_s_data     stream word
//   o_s_ready    loader accepts the word this cycle
//   o_mem_we     bank write strobe (registered, one cycle after a transfer)
//   o_mem_bank   target bank index
//   o_mem_addr   word address within the bank
//   o_mem_data   write data
//   o_busy       load in progress
//   o_done       one-cycle pulse when the load completes
//   o_cksum_err  checksum mismatch flag (0 without WB_LOADER_CKSUM_EN)
//   o_dbg_state  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module wb_loader #(
    parameter int L1_BANKS = 32,
    parameter int L2_BANKS = 10,
    parameter int L1_WORDS = 785,
    parameter int L2_WORDS = 33,
    parameter int DEPTH    = 1024
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_start,
    input  logic        i_s_valid,
    input  logic [31:0] i_s_data,
    output logic        o_s_ready,
    output logic        o_mem_we,
    output logic [5:0]  o_mem_bank,
    output logic [9:0]  o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_cksum_err,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD1 = 3'd1,
        S_LOAD2 = 3'd2,
        S_DONE  = 3'd3
`ifdef WB_LOADER_CKSUM_EN
        , S_CHK = 3'd4
`endif
    } state_t;

    // Last word index of a bank, clamped so the word counter never runs
    // past the bank depth even with an inconsistent parameter set.
    localparam logic [9:0] L1_LAST_WORD =
        (L1_WORDS <= DEPTH) ? 10'(L1_WORDS - 1) : 10'(DEPTH - 1);
    localparam logic [9:0] L2_LAST_WORD =
        (L2_WORDS <= DEPTH) ? 10'(L2_WORDS - 1) : 10'(DEPTH - 1);
    localparam logic [5:0] L1_LAST_BANK = 6'(L1_BANKS - 1);
    localparam logic [5:0] L2_LAST_BANK = 6'(L1_BANKS + L2_BANKS - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_bank;
    logic [9:0]  r_word;

    logic        r_mem_we;
    logic [5:0]  r_mem_bank;
    logic [9:0]  r_mem_addr;
    logic [31:0] r_mem_data;

    logic        w_xfer;
    logic        w_in_load;
    logic        w_load_xfer;
    logic        w_word_last;
    logic        w_l1_end;
    logic        w_l2_end;
    logic        w_start_idle;

    // -------------------------------------------------------------------------
    // Transfer qualification
    // -------------------------------------------------------------------------
    assign w_xfer       = i_s_valid && o_s_ready;
    assign w_in_load    = (r_state == S_LOAD1) || (r_state == S_LOAD2);
    assign w_load_xfer  = w_xfer && w_in_load;
    assign w_start_idle = (r_state == S_IDLE) && i_start;

    // The bank length depends on which layer is being filled.
    assign w_word_last  = (r_state == S_LOAD1) ? (r_word == L1_LAST_WORD)
                                               : (r_word == L2_LAST_WORD);
    assign w_l1_end     = (r_state == S_LOAD1) && w_word_last && (r_bank == L1_LAST_BANK);
    assign w_l2_end     = (r_state == S_LOAD2) && w_word_last && (r_bank == L2_LAST_BANK);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_LOAD1;
                end
            end
            S_LOAD1: begin
                if (w_xfer && w_l1_end) begin
                    w_next_state = S_LOAD2;
                end
            end
            S_LOAD2: begin
                if (w_xfer && w_l2_end) begin
`ifdef WB_LOADER_CKSUM_EN
                    w_next_state = S_CHK;
`else
                    w_next_state = S_DONE;
`endif
                end
            end
`ifdef WB_LOADER_CKSUM_EN
            S_CHK: begin
                // Exactly one word (the expected checksum) is taken here.
                if (w_xfer) begin
                    w_next_state = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_s_ready = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            S_LOAD1, S_LOAD2: begin
                o_s_ready = 1'b1;
                o_busy    = 1'b1;
            end
`ifdef WB_LOADER_CKSUM_EN
            S_CHK: begin
                o_s_ready = 1'b1;
                o_busy    = 1'b1;
            end
`endif
            S_DONE: begin
                o_done    = 1'b1;
            end
            default: begin
                o_s_ready = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bank / word counters. A start seen while busy or in DONE does not
    // touch them; only a start from IDLE rewinds to bank 0, word 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_bank <= 6'd0;
            r_word <= 10'd0;
        end else if (w_start_idle) begin
            r_bank <= 6'd0;
            r_word <= 10'd0;
        end else if (w_load_xfer) begin
            if (w_word_last) begin
                // Wrap the word index; the bank index simply carries on,
                // so layer 2 starts at L1_BANKS without special casing.
                r_word <= 10'd0;
                r_bank <= r_bank + 6'd1;
            end else begin
                r_word <= r_word + 10'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered bank write port. Address/data hold while the strobe is low.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_mem_we   <= 1'b0;
            r_mem_bank <= 6'd0;
            r_mem_addr <= 10'd0;
            r_mem_data <= 32'd0;
        end else begin
            r_mem_we <= w_load_xfer;
            if (w_load_xfer) begin
                r_mem_bank <= r_bank;
                r_mem_addr <= r_word;
                r_mem_data <= i_s_data;
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_bank  = r_mem_bank;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_dbg_state = r_state;

    // -------------------------------------------------------------------------
    // Optional checksum
    // -------------------------------------------------------------------------
`ifdef WB_LOADER_CKSUM_EN
    logic [31:0] r_sum;
    logic        r_cksum_err;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sum       <= 32'd0;
            r_cksum_err <= 1'b0;
        end else if (w_start_idle) begin
            r_sum       <= 32'd0;
            r_cksum_err <= 1'b0;
        end else if (w_load_xfer) begin
            r_sum <= r_sum + i_s_data;
        end else if ((r_state == S_CHK) && w_xfer) begin
            r_cksum_err <= (i_s_data != r_sum);
        end
    end

    assign o_cksum_err = r_cksum_err;
`else
    assign o_cksum_err = 1'b0;
`endif

endmodule

// File: doc/wb_loader.md
Name: wb_loader

Overview:
- Writer side of the weight/bias memory bank set: fills the 42 weight/bias banks at run time instead of from files.
- Banks 0-31 hold [W1|b1]; banks 32-41 hold [W2|b2].
- Accepts a 32-bit word stream over a valid/ready handshake and emits one registered bank write per accepted word.
- Sits between the picoRV32 bus/DMA side and the weight/bias banks, and signals completion to the inference controller.

Parameters:
- L1_BANKS, 32, number of layer-1 banks (bank indices 0..L1_BANKS-1)
- L2_BANKS, 10, number of layer-2 banks (bank indices L1_BANKS..L1_BANKS+L2_BANKS-1)
- L1_WORDS, 785, words written per layer-1 bank (784 weights + 1 bias)
- L2_WORDS, 33, words written per layer-2 bank (32 weights + 1 bias)
- DEPTH, 1024, bank depth; L1_WORDS and L2_WORDS must be <= DEPTH

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load when idle
- s_valid  in  1  stream word valid
- s_data  in  32  stream word
- s_ready  out  1  loader accepts the word this cycle
- mem_we  out  1  bank write strobe (registered)
- mem_bank  out  6  target bank index
- mem_addr  out  10  word address within bank
- mem_data  out  32  write data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the load completes
- cksum_err  out  1  checksum mismatch flag (optional feature)

Behaviour:
- Reset (async, resetn=0): state=IDLE; s_ready, mem_we, busy, done, cksum_err = 0; mem_bank, mem_addr, mem_data, bank/word counters = 0.
- States: IDLE, LOAD1, LOAD2, CHK (present only with the optional feature), DONE.
- IDLE: s_ready=0, busy=0. On start=1: clear counters and cksum_err, go to LOAD1.
- Handshake: a word transfers on any cycle with s_valid && s_ready. s_ready=1 in LOAD1, LOAD2 and CHK, else 0. s_data is sampled only on a transfer.
- LOAD1/LOAD2 transfer: on the next edge, mem_we=1, mem_bank=bank counter, mem_addr=word counter, mem_data=s_data. Latency is 1 cycle, with no backpressure from the memory side. mem_we=0 on every cycle without a transfer. mem_bank/mem_addr/mem_data hold their values when mem_we=0.
- Order is bank-major: word counter runs 0..Lx_WORDS-1, then wraps to 0 and the bank counter increments.
- Transition LOAD1 -> LOAD2 on the transfer at bank L1_BANKS-1, word L1_WORDS-1. The bank counter continues at L1_BANKS (32).
- Transition LOAD2 -> DONE (or CHK when the feature is enabled) on the transfer at bank L1_BANKS+L2_BANKS-1, word L2_WORDS-1.
- DONE: lasts one cycle. done=1, busy=0, then IDLE. mem_we for the final word is asserted in this same cycle.
- busy=1 in LOAD1, LOAD2 and CHK.
- start while busy or in DONE: ignored.
- start and s_valid in the same cycle while IDLE: the word is not accepted, because s_ready=0 in IDLE.
- s_valid gaps: counters hold, no write.
- Reset mid-load: everything returns to reset values. Partially written banks are not restored. A new start reloads from bank 0, word 0.
- Counters never exceed DEPTH-1; word address width is 10 bits, bank width is 6 bits.

Optional Feature:
- Macro WB_LOADER_CKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) of every data word transferred in LOAD1/LOAD2 is kept; it is cleared on start.
  - After the last LOAD2 word the FSM enters CHK and accepts exactly one more stream word, the expected checksum. This word is not written to any bank.
  - On that transfer, cksum_err = (word != sum), then the FSM goes to DONE.
  - cksum_err holds its value until the next start or reset.
- Not defined: no CHK state, no sum register, cksum_err tied to 0, and LOAD2 goes directly to DONE.

Test Plan:
- Full default load: start, then 25450 words of ramp data (0,1,2,...) with s_valid held at 1 -> first write is bank 0, addr 0, data 0. The word at index 785 lands at bank 1, addr 0. Index 25120 lands at bank 32, addr 0. Last word lands at bank 41, addr 32. done pulses 1 cycle after the last write is issued, concurrent with that mem_we.
- Backpressure: s_valid toggles 1/0 every cycle -> mem_we asserts only on transfer+1 cycles; addresses remain contiguous with no skipped or repeated address.
- Ignored start: pulse start at word 100 of a load -> no counter reset; the load completes normally with exactly 25450 writes.
- Reset mid-load: drop resetn at word 5000 -> all outputs read 0 immediately (async). Then start with fresh data -> first write is bank 0, addr 0.
- Idle stream: s_valid=1 with data 0xDEADBEEF before any start -> s_ready=0, no mem_we, busy=0.
- With WB_LOADER_CKSUM_EN:
  - Load of all 1s, then checksum word 25450 (0x636A) -> cksum_err=0 and done=1.
  - Same load with checksum word 0x636B -> cksum_err=1 after done.
  - Neither checksum word produces a mem_we.
